// File: rtl/merger_tree_nway_if.sv
// Handshake bundle between the N input streams, the merged output stream and merger_tree_nway.
interface merger_tree_nway_if #(
  parameter int NUM_INPUTS = 4,
  parameter int KEY_W      = 32,
  parameter int VAL_W      = 32,
  parameter int CNT_W      = 16
);
  logic [NUM_INPUTS-1:0]       in_valid;
  logic [NUM_INPUTS-1:0]       in_ready;
  logic [NUM_INPUTS*KEY_W-1:0] in_key;
  logic [NUM_INPUTS*VAL_W-1:0] in_val;
  logic [NUM_INPUTS-1:0]       in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [KEY_W-1:0]            out_key;
  logic [VAL_W-1:0]            out_val;
  logic                        out_last;
  logic [CNT_W-1:0]            out_count;
  logic                        order_err;

  modport master (
    output in_valid, in_key, in_val, in_last, out_ready,
    input  in_ready, out_valid, out_key, out_val, out_last, out_count, order_err
  );

  modport slave (
    input  in_valid, in_key, in_val, in_last, out_ready,
    output in_ready, out_valid, out_key, out_val, out_last, out_count, order_err
  );
endinterface

// File: rtl/merger_tree_nway.sv
// N-way ascending (key, value) merger: a registered binary tree in heap numbering, where
// node n consumes nodes 2n and 2n+1 and positions >= NUM_INPUTS are the input streams.
module merger_tree_nway #(
  parameter int NUM_INPUTS = 4,
  parameter int KEY_W      = 32,
  parameter int VAL_W      = 32,
  parameter bit COMBINE    = 1'b1,
  parameter int CNT_W      = 16
) (
  input logic               clock,
  input logic               reset,
  merger_tree_nway_if.slave io
);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_INPUTS-1:0] in_ready_s;
  logic [NUM_INPUTS-1:0] in_fire_s;
  logic [NUM_INPUTS-1:0] in_row_r;
  logic [KEY_W-1:0]      prev_key_r [NUM_INPUTS];
  logic                  err_hit_s;
  logic                  order_err_r;
  logic [CNT_W-1:0]      count_r;
  logic                  out_fire_s;

  for (genvar n = 1; n < NUM_INPUTS; n++) begin : g_node
    logic             valid_r, last_r, done_a_r, done_b_r;
    logic [KEY_W-1:0] key_r;
    logic [VAL_W-1:0] val_r;
    logic             a_valid_s, b_valid_s, a_last_s, b_last_s;
    logic [KEY_W-1:0] a_key_s, b_key_s, nkey_s;
    logic [VAL_W-1:0] a_val_s, b_val_s, nval_s;
    logic             down_ready_s, can_load_s, take_a_s, take_b_s, load_s;
    logic             ready_a_s, ready_b_s, nd_a_s, nd_b_s;

    if (2 * n >= NUM_INPUTS) begin : g_leaf
      localparam int IA = 2 * n - NUM_INPUTS;
      assign a_valid_s = io.in_valid[IA];
      assign a_key_s   = io.in_key[IA*KEY_W +: KEY_W];
      assign a_val_s   = io.in_val[IA*VAL_W +: VAL_W];
      assign a_last_s  = io.in_last[IA];
      assign b_valid_s = io.in_valid[IA+1];
      assign b_key_s   = io.in_key[(IA+1)*KEY_W +: KEY_W];
      assign b_val_s   = io.in_val[(IA+1)*VAL_W +: VAL_W];
      assign b_last_s  = io.in_last[IA+1];
      assign in_ready_s[IA]   = ready_a_s;
      assign in_ready_s[IA+1] = ready_b_s;
    end else begin : g_inner
      assign a_valid_s = g_node[2*n].valid_r;
      assign a_key_s   = g_node[2*n].key_r;
      assign a_val_s   = g_node[2*n].val_r;
      assign a_last_s  = g_node[2*n].last_r;
      assign b_valid_s = g_node[2*n+1].valid_r;
      assign b_key_s   = g_node[2*n+1].key_r;
      assign b_val_s   = g_node[2*n+1].val_r;
      assign b_last_s  = g_node[2*n+1].last_r;
    end

    if (n == 1) begin : g_root
      assign down_ready_s = io.out_ready;
    end else if (n % 2 == 0) begin : g_left
      assign down_ready_s = g_node[n/2].ready_a_s;
    end else begin : g_right
      assign down_ready_s = g_node[n/2].ready_b_s;
    end

    // Selection: a side that has finished its row is frozen until the partner finishes too.
    always_comb begin
      can_load_s = !valid_r || down_ready_s;
      take_a_s   = a_valid_s && !done_a_r &&
                   (done_b_r || (b_valid_s && !done_b_r && (a_key_s <= b_key_s)));
      take_b_s   = b_valid_s && !done_b_r &&
                   (done_a_r || (a_valid_s && !done_a_r &&
                    ((b_key_s < a_key_s) || (COMBINE && (a_key_s == b_key_s)))));
      load_s     = can_load_s && (take_a_s || take_b_s);
      ready_a_s  = can_load_s && !done_a_r && (!a_valid_s || take_a_s);
      ready_b_s  = can_load_s && !done_b_r && (!b_valid_s || take_b_s);
      nd_a_s     = done_a_r || (take_a_s && a_last_s);
      nd_b_s     = done_b_r || (take_b_s && b_last_s);
      nkey_s     = take_a_s ? a_key_s : b_key_s;
      nval_s     = (take_a_s && take_b_s) ? (a_val_s + b_val_s) :
                   (take_a_s ? a_val_s : b_val_s);
    end

    // Node output register and per-side row-done flags.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_r  <= 1'b0;
        key_r    <= {KEY_W{1'b0}};
        val_r    <= {VAL_W{1'b0}};
        last_r   <= 1'b0;
        done_a_r <= 1'b0;
        done_b_r <= 1'b0;
      end else if (load_s) begin
        valid_r  <= 1'b1;
        key_r    <= nkey_s;
        val_r    <= nval_s;
        last_r   <= nd_a_s && nd_b_s;
        done_a_r <= nd_a_s && !nd_b_s;
        done_b_r <= nd_b_s && !nd_a_s;
      end else if (down_ready_s) begin
        valid_r  <= 1'b0;
      end else begin
        valid_r  <= valid_r;
      end
    end
  end

  assign in_fire_s    = io.in_valid & in_ready_s;
  assign out_fire_s   = g_node[1].valid_r && io.out_ready;
  assign io.in_ready  = in_ready_s;
  assign io.out_valid = g_node[1].valid_r;
  assign io.out_key   = g_node[1].key_r;
  assign io.out_val   = g_node[1].val_r;
  assign io.out_last  = g_node[1].last_r;
  assign io.out_count = count_r;
  assign io.order_err = order_err_r;

  // Flags any accepted key that does not strictly exceed the previous key of the same row.
  always_comb begin
    err_hit_s = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      err_hit_s = err_hit_s | (in_fire_s[i] && in_row_r[i] &&
                               (io.in_key[i*KEY_W +: KEY_W] <= prev_key_r[i]));
    end
  end

  // Per-stream previous-key tracking and the sticky order error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      order_err_r <= 1'b0;
      in_row_r    <= {NUM_INPUTS{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) prev_key_r[i] <= {KEY_W{1'b0}};
    end else begin
      order_err_r <= order_err_r | err_hit_s;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (in_fire_s[i]) begin
          prev_key_r[i] <= io.in_key[i*KEY_W +: KEY_W];
          in_row_r[i]   <= !io.in_last[i];
        end else begin
          prev_key_r[i] <= prev_key_r[i];
        end
      end
    end
  end

  // Output item counter: shows the 1-based position of the presented item within its row.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ONE;
    end else if (out_fire_s) begin
      if (g_node[1].last_r) count_r <= CNT_ONE;
      else if (count_r != CNT_MAX) count_r <= count_r + CNT_ONE;
      else count_r <= count_r;
    end else begin
      count_r <= count_r;
    end
  end
endmodule

// File: tb/tb_merger_tree_nway.sv
// Directed bench for merger_tree_nway: per-stream input queues, output capture, hand-computed rows.
module tb_merger_tree_nway;
  localparam int N = 4, KW = 32, VW = 32, CW = 16;

  typedef struct packed {
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    logic          l;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  merger_tree_nway_if #(.NUM_INPUTS(N), .KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) bus1 ();
  merger_tree_nway_if #(.NUM_INPUTS(N), .KEY_W(KW), .VAL_W(VW), .CNT_W(CW)) bus0 ();

  merger_tree_nway #(.NUM_INPUTS(N), .KEY_W(KW), .VAL_W(VW), .COMBINE(1'b1), .CNT_W(CW))
    dut1 (.clock(clk), .reset(rst_n), .io(bus1));
  merger_tree_nway #(.NUM_INPUTS(N), .KEY_W(KW), .VAL_W(VW), .COMBINE(1'b0), .CNT_W(CW))
    dut0 (.clock(clk), .reset(rst_n), .io(bus0));

  // sel0 routes the stimulus to the COMBINE=0 instance; the idle one sees no valid inputs.
  logic sel0 = 1'b0;
  logic [N-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [N*KW-1:0] in_key = '0;
  logic [N*VW-1:0] in_val = '0;
  logic out_ready = 1'b1, out_valid, out_last, order_err;
  logic [KW-1:0] out_key;
  logic [VW-1:0] out_val;
  logic [CW-1:0] out_count;

  assign bus1.in_valid = sel0 ? '0 : in_valid;
  assign bus0.in_valid = sel0 ? in_valid : '0;
  assign bus1.in_key = in_key;   assign bus0.in_key = in_key;
  assign bus1.in_val = in_val;   assign bus0.in_val = in_val;
  assign bus1.in_last = in_last; assign bus0.in_last = in_last;
  assign bus1.out_ready = out_ready; assign bus0.out_ready = out_ready;
  assign in_ready  = sel0 ? bus0.in_ready  : bus1.in_ready;
  assign out_valid = sel0 ? bus0.out_valid : bus1.out_valid;
  assign out_key   = sel0 ? bus0.out_key   : bus1.out_key;
  assign out_val   = sel0 ? bus0.out_val   : bus1.out_val;
  assign out_last  = sel0 ? bus0.out_last  : bus1.out_last;
  assign out_count = sel0 ? bus0.out_count : bus1.out_count;
  assign order_err = sel0 ? bus0.order_err : bus1.order_err;

  int ncheck = 0, nbad = 0, cyc = 0, first_in = -1, first_out = -1;
  item_t sq [N][$];
  item_t oq[$], eq[$];
  logic [CW-1:0] cq[$], ec[$];
  logic stall_en = 1'b0;
  logic [3:0] stall_pat = 4'b1001;
  logic held = 1'b0, h_last;
  logic [KW-1:0] h_key;
  logic [VW-1:0] h_val;
  logic [CW-1:0] h_cnt;
  logic exp_err = 1'b0;
  logic [N-1:0] mrow = '0;
  logic [KW-1:0] mprev [N];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_in(input int s, input int k, input int v, input logic l);
    item_t it;
    it.k = k; it.v = v; it.l = l;
    sq[s].push_back(it);
  endtask

  task automatic push_exp(input int k, input int v, input logic l, input int c);
    item_t it;
    it.k = k; it.v = v; it.l = l;
    eq.push_back(it);
    ec.push_back(c[CW-1:0]);
  endtask

  task automatic cycle();
    logic [N-1:0] fire;
    @(negedge clk);
    out_ready = stall_en ? stall_pat[cyc % 4] : 1'b1;
    for (int i = 0; i < N; i++) begin
      if (sq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        in_key[i*KW +: KW] = sq[i][0].k;
        in_val[i*VW +: VW] = sq[i][0].v;
        in_last[i] = sq[i][0].l;
      end else begin
        in_valid[i] = 1'b0;
        in_key[i*KW +: KW] = '0;
        in_val[i*VW +: VW] = '0;
        in_last[i] = 1'b0;
      end
    end
    #1;
    check_val("order_err", order_err, exp_err);
    if (held) begin
      check_val("hold_valid", out_valid, 1'b1);
      check_val("hold_key", out_key, h_key);
      check_val("hold_val", out_val, h_val);
      check_val("hold_last", out_last, h_last);
      check_val("hold_count", out_count, h_cnt);
    end
    held = out_valid && !out_ready;
    h_key = out_key; h_val = out_val; h_last = out_last; h_cnt = out_count;
    if (out_valid && first_out < 0) first_out = cyc;
    if (out_valid && out_ready) begin
      item_t it;
      it.k = out_key; it.v = out_val; it.l = out_last;
      oq.push_back(it);
      cq.push_back(out_count);
    end
    fire = in_valid & in_ready;
    if (fire != '0 && first_in < 0) first_in = cyc;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        if (mrow[i] && in_key[i*KW +: KW] <= mprev[i]) exp_err = 1'b1;
        mprev[i] = in_key[i*KW +: KW];
        mrow[i] = !in_last[i];
        void'(sq[i].pop_front());
      end
    end
    cyc++;
  endtask

  // Runs until the expected number of outputs arrived (bounded), idles, then compares the row.
  task automatic run_row(input string tag);
    int budget = 0;
    oq.delete(); cq.delete();
    first_in = -1; first_out = -1;
    while (oq.size() < eq.size() && budget < 300) begin
      cycle();
      budget++;
    end
    repeat (4) cycle();
    check_val({tag, ".len"}, oq.size(), eq.size());
    for (int j = 0; j < eq.size() && j < oq.size(); j++) begin
      check_val($sformatf("%s[%0d].key", tag, j), oq[j].k, eq[j].k);
      check_val($sformatf("%s[%0d].val", tag, j), oq[j].v, eq[j].v);
      check_val($sformatf("%s[%0d].last", tag, j), oq[j].l, eq[j].l);
      check_val($sformatf("%s[%0d].count", tag, j), cq[j], ec[j]);
    end
    eq.delete(); ec.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    in_valid = '0;
    for (int i = 0; i < N; i++) sq[i].delete();
    held = 1'b0; exp_err = 1'b0; mrow = '0;
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, ".out_valid"}, out_valid, 1'b0);
    check_val({tag, ".out_key"}, out_key, 32'd0);
    check_val({tag, ".out_val"}, out_val, 32'd0);
    check_val({tag, ".out_last"}, out_last, 1'b0);
    check_val({tag, ".out_count"}, out_count, 16'd1);
    check_val({tag, ".order_err"}, order_err, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    apply_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("reset");
    check_val("reset.in_ready", in_ready, 4'hF);

    // Basic merge of unequal rows, with first-output latency.
    push_in(0, 1, 1, 1'b0); push_in(0, 5, 5, 1'b1);
    push_in(1, 2, 2, 1'b1);
    push_in(2, 3, 3, 1'b0); push_in(2, 9, 9, 1'b1);
    push_in(3, 4, 4, 1'b1);
    push_exp(1, 1, 1'b0, 1); push_exp(2, 2, 1'b0, 2); push_exp(3, 3, 1'b0, 3);
    push_exp(4, 4, 1'b0, 4); push_exp(5, 5, 1'b0, 5); push_exp(9, 9, 1'b1, 6);
    run_row("basic");
    check_val("basic.latency", first_out - first_in, 2);

    // Four equal keys summed into one item.
    push_in(0, 7, 10, 1'b1); push_in(1, 7, 20, 1'b1);
    push_in(2, 7, 30, 1'b1); push_in(3, 7, 40, 1'b1);
    push_exp(7, 100, 1'b1, 1);
    run_row("combine");

    // Same input on the non-combining instance: lower-indexed subtree first.
    sel0 = 1'b1;
    push_in(0, 7, 10, 1'b1); push_in(1, 7, 20, 1'b1);
    push_in(2, 7, 30, 1'b1); push_in(3, 7, 40, 1'b1);
    push_exp(7, 10, 1'b0, 1); push_exp(7, 20, 1'b0, 2);
    push_exp(7, 30, 1'b0, 3); push_exp(7, 40, 1'b1, 4);
    run_row("nocombine");
    sel0 = 1'b0;

    // Keys 1..8, first free-running, then under a 1,0,0,1 out_ready pattern.
    for (int pass = 0; pass < 2; pass++) begin
      stall_en = (pass == 1);
      for (int s = 0; s < N; s++) begin
        push_in(s, s + 1, s + 101, 1'b0);
        push_in(s, s + 5, s + 105, 1'b1);
      end
      for (int k = 1; k <= 8; k++) push_exp(k, k + 100, (k == 8), k);
      run_row(pass == 0 ? "spread" : "stall");
    end
    stall_en = 1'b0;

    // Out-of-order stream 0 raises the sticky error while data still flows.
    check_val("err.before", order_err, 1'b0);
    push_in(0, 5, 5, 1'b0); push_in(0, 3, 3, 1'b1);
    push_in(1, 4, 4, 1'b1); push_in(2, 6, 6, 1'b1); push_in(3, 7, 7, 1'b1);
    push_exp(4, 4, 1'b0, 1); push_exp(5, 5, 1'b0, 2); push_exp(3, 3, 1'b0, 3);
    push_exp(6, 6, 1'b0, 4); push_exp(7, 7, 1'b1, 5);
    run_row("err_row");
    check_val("err.after", order_err, 1'b1);
    for (int s = 0; s < N; s++) push_in(s, 10 + s, 10 + s, 1'b1);
    for (int k = 10; k <= 13; k++) push_exp(k, k, (k == 13), k - 9);
    run_row("err_next");
    check_val("err.sticky", order_err, 1'b1);

    // Reset with three items in flight, then a clean row.
    push_in(0, 20, 20, 1'b0); push_in(0, 30, 30, 1'b1);
    push_in(1, 21, 21, 1'b1);
    push_in(2, 22, 22, 1'b0); push_in(2, 32, 32, 1'b1);
    push_in(3, 23, 23, 1'b1);
    cycle(); cycle();
    #1;
    check_val("midrst.pre_valid", out_valid, 1'b1);
    check_val("midrst.pre_key", out_key, 32'd20);
    #1;
    apply_reset();
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("midrst.in_ready", in_ready, 4'hF);
    check_val("midrst.rel_valid", out_valid, 1'b0);
    for (int s = 0; s < N; s++) push_in(s, 40 + s, 40 + s, 1'b1);
    for (int k = 40; k <= 43; k++) push_exp(k, k, (k == 43), k - 39);
    run_row("after_rst");

    $display("test done: total=%0d bad=%0d", ncheck, nbad);
    $finish;
  end
endmodule

// File: doc/merger_tree_nway.md
Name: merger_tree_nway

Overview:
- Parametrised N-way sorted-stream merger for the SpGEMM merge datapath; successor to the fixed 4-input, three-binary-merger tree.
- Merges NUM_INPUTS ascending (key, value) streams into one ascending output stream.
- Handshaking is valid/ready.
- One register stage per tree level, per-stream end-of-row tracking, optional accumulation of equal keys, and a sticky input-order error flag.

Parameters:
- NUM_INPUTS, 4, number of input streams; power of 2, ≥2; LEVELS = log2(NUM_INPUTS).
- KEY_W, 32, coordinate width.
- VAL_W, 32, value width.
- COMBINE, 1, 1 = equal keys from two subtrees are summed into one item; 0 = emitted separately, lower-indexed subtree first.
- CNT_W, 16, width of the output item counter.

Ports:
- clock  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  NUM_INPUTS  per-stream item valid.
- in_ready  out  NUM_INPUTS  per-stream accept.
- in_key  in  NUM_INPUTS*KEY_W  stream i at [i*KEY_W +: KEY_W].
- in_val  in  NUM_INPUTS*VAL_W  stream i at [i*VAL_W +: VAL_W].
- in_last  in  NUM_INPUTS  item is final of its stream's current row.
- out_valid  out  1  merged item valid.
- out_ready  in  1  downstream accept.
- out_key  out  KEY_W  merged key.
- out_val  out  VAL_W  merged (possibly summed) value.
- out_last  out  1  final item of the merged row.
- out_count  out  CNT_W  items emitted in current merged row, including the current one.
- order_err  out  1  sticky; a stream delivered a non-increasing key.

Behaviour:
- Transfer occurs on any port when valid & ready at a rising clock edge. Each input stream carries ≥1 item per row; empty rows are not supported.
- Tree: NUM_INPUTS-1 two-input nodes in LEVELS levels. Each node owns one output register (valid, key, val, last) and a done flag per input side.
- Node ready to its children: ready_out = !reg_valid | downstream_ready. The ready chain is combinational through the tree.
- Node fire condition, with the register able to load:
  - both sides valid; or
  - one side valid and the other side done.
- Node selection:
  - Smaller key wins; only the winner is popped.
  - Equal keys, COMBINE=1: pop both; val = sum modulo 2^VAL_W.
  - Equal keys, COMBINE=0: pop side 0 only.
- Done flag for a side sets when that side transfers an item with last=1. Registered last = 1 when, after this pop, both sides are done. On that load, both done flags clear so the next row starts clean.
- Equal keys with one side last, COMBINE=1: both popped; last is set only if both sides are then done.
- Latency: an item accepted at an input in cycle t appears on out_* at earliest t+LEVELS, given partners available and no backpressure.
- Throughput: 1 item/cycle sustained when out_ready=1.
- out_count:
  - Reset value 1.
  - Increments on each output transfer without out_last.
  - Returns to 1 on a transfer with out_last.
  - Saturates at 2^CNT_W-1.
- order_err:
  - Per-stream previous-key register, valid only between the first and last item of a row.
  - Set when an accepted key ≤ previous key in the same row.
  - Clears only on reset. Data still flows when it is set.
- Reset (asynchronous, any time, including mid-row):
  - All node registers invalid, done flags and order_err 0, out_count 1.
  - out_valid=0, out_key=0, out_val=0, out_last=0.
  - in_ready is 1 for all streams in the first cycle after release.
- Backpressure: when out_ready=0 and out_valid=1, out_* hold stable until transferred. No item is lost or duplicated.
- Streams may run ahead into the next row only through registers already freed. A node never mixes rows, because done gates its firing.

Test Plan:
- NUM_INPUTS=4, COMBINE=1, streams {1,5},{2},{3,9},{4}, each value=key, out_ready=1 → out keys 1,2,3,4,5,9; first valid 2 cycles after inputs; out_last only on 9; out_count 1..6.
- COMBINE=1, streams {7 v=10},{7 v=20},{7 v=30},{7 v=40} → single item key 7, val 100, out_last=1, out_count=1.
- COMBINE=0, same as above → four items key 7 with vals 10,20,30,40 in that order; out_last on the 4th.
- Keys 1..8 spread over 4 streams; toggle out_ready 1,0,0,1 repeatedly → output identical to the unstalled run; out_* stable during stalls.
- Stream 0 sends 5 then 3 → order_err=1 from the cycle after acceptance and stays 1 across further rows; merge output still delivered.
- Assert reset mid-row with 3 items in flight → out_valid=0 immediately, no stale items after release, next row merges correctly starting at out_count=1.
